// File: rtl/seq_cmp_pkg.sv
// Shared constants and FSM encoding for the digit-serial magnitude comparator.
package seq_cmp_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DIGIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Width of a counter indexing n items; never narrower than one bit.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_digit_compare.sv
// Combinational unsigned compare of one DIGIT-bit slice of each operand.
module digit_compare
  import seq_cmp_pkg::*;
#(
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output logic             o_gt,
  output logic             o_lt,
  output logic             o_eq
);

  assign o_gt = (i_a >  i_b);
  assign o_lt = (i_a <  i_b);
  assign o_eq = (i_a == i_b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Digit-serial magnitude comparator: walks operands MSB digit first and stops
// at the first differing digit. Signed mode flips the sign bits at capture.
module seq_magnitude_comparator
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             a_lt_b,
  output logic             a_gt_b,
  output logic             a_eq_b
);

  localparam int N   = WIDTH / DIGIT;
  localparam int K_W = index_width(N);
  localparam logic [K_W-1:0]   K_LAST    = K_W'(N - 1);
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [K_W-1:0]   r_k;
  logic             r_lt;
  logic             r_gt;
  logic             r_eq;

  logic [WIDTH-1:0] w_a_shift;
  logic [WIDTH-1:0] w_b_shift;
  logic             w_dig_gt;
  logic             w_dig_lt;
  logic             w_dig_eq;
  logic             w_load;
  logic             w_advance;
  logic             w_finish;

  // Bring digit k to the top so a fixed slice feeds the digit comparator.
  assign w_a_shift = r_a << (r_k * DIGIT);
  assign w_b_shift = r_b << (r_k * DIGIT);

  digit_compare #(
    .DIGIT (DIGIT)
  ) u_digit_compare (
    .i_a  (w_a_shift[WIDTH-1 -: DIGIT]),
    .i_b  (w_b_shift[WIDTH-1 -: DIGIT]),
    .o_gt (w_dig_gt),
    .o_lt (w_dig_lt),
    .o_eq (w_dig_eq)
  );

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (!w_dig_eq || (r_k == K_LAST)) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_advance = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_COMPARE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_k <= '0;
    end else if (w_load) begin
      r_a <= a ^ (is_signed ? SIGN_MASK : '0);
      r_b <= b ^ (is_signed ? SIGN_MASK : '0);
      r_k <= '0;
    end else if (w_advance) begin
      r_k <= r_k + 1'b1;
    end
  end

  // Flags load on the edge entering DONE, so they change with the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lt <= 1'b0;
      r_gt <= 1'b0;
      r_eq <= 1'b0;
    end else if (w_finish) begin
      r_lt <= w_dig_lt;
      r_gt <= w_dig_gt;
      r_eq <= w_dig_eq;
    end
  end

  assign busy   = (r_state == ST_COMPARE);
  assign done   = (r_state == ST_DONE);
  assign a_lt_b = r_lt;
  assign a_gt_b = r_gt;
  assign a_eq_b = r_eq;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator (WIDTH=16, DIGIT=4) with
// hand-computed latencies and flags.
module tb_seq_magnitude_comparator;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             busy;
  logic             done;
  logic             a_lt_b;
  logic             a_gt_b;
  logic             a_eq_b;

  int n_tests = 0;
  int n_fail  = 0;

  seq_magnitude_comparator #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .busy      (busy),
    .done      (done),
    .a_lt_b    (a_lt_b),
    .a_gt_b    (a_gt_b),
    .a_eq_b    (a_eq_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] flags();
    return {a_lt_b, a_gt_b, a_eq_b};
  endfunction

  // Drives start with operands so that it is accepted at the next rising
  // edge (edge 0); returns 1 ns after that edge, inside cycle 1.
  task automatic launch(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vs);
    @(negedge clk);
    start     = 1'b1;
    a         = va;
    b         = vb;
    is_signed = vs;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts cycles after the launching edge until done is seen mid-cycle.
  // cyc = -1 if the budget runs out; busy1 is busy sampled in cycle 1.
  task automatic wait_done(output int cyc, output logic busy1);
    bit found;
    found = 1'b0;
    cyc   = -1;
    busy1 = 1'b0;
    for (int c = 1; c <= 40 && !found; c++) begin
      @(negedge clk);
      if (c == 1) busy1 = busy;
      if (done) begin
        cyc   = c;
        found = 1'b1;
      end
    end
  endtask

  task automatic run_case(input string tag, input logic [WIDTH-1:0] va,
                          input logic [WIDTH-1:0] vb, input logic vs,
                          input logic [2:0] exp_flags, input int exp_cyc);
    int   cyc;
    logic b1;
    launch(va, vb, vs);
    wait_done(cyc, b1);
    check({tag, ".latency"}, cyc, exp_cyc);
    check({tag, ".busy_c1"}, b1, 1'b1);
    check({tag, ".flags"}, flags(), exp_flags);
    @(negedge clk);
    check({tag, ".one_pulse"}, done, 1'b0);
    check({tag, ".hold"}, flags(), exp_flags);
    check({tag, ".idle"}, busy, 1'b0);
  endtask

  initial begin
    int   cyc;
    logic b1;
    bit   seen_done;

    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    is_signed = 1'b0;
    #12;
    check("reset.busy", busy, 1'b0);
    check("reset.done", done, 1'b0);
    check("reset.flags", flags(), 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // flags are {lt, gt, eq}
    run_case("u_lt_last",  16'h1234, 16'h1235, 1'b0, 3'b100, 5);
    run_case("u_gt_early", 16'hA000, 16'h1000, 1'b0, 3'b010, 2);
    run_case("s_lt_early", 16'hA000, 16'h1000, 1'b1, 3'b100, 2);
    run_case("u_eq",       16'hBEEF, 16'hBEEF, 1'b0, 3'b001, 5);
    run_case("s_eq",       16'hBEEF, 16'hBEEF, 1'b1, 3'b001, 5);
    run_case("s_min_max",  16'h8000, 16'h7FFF, 1'b1, 3'b100, 2);
    run_case("s_m1_zero",  16'hFFFF, 16'h0000, 1'b1, 3'b100, 2);
    run_case("u_max_zero", 16'hFFFF, 16'h0000, 1'b0, 3'b010, 2);

    // Second start during COMPARE with new operands must be ignored, and the
    // changed inputs must not disturb the captured operands.
    launch(16'h1234, 16'h1235, 1'b0);
    start     = 1'b1;
    a         = 16'hFFFF;
    b         = 16'h0000;
    is_signed = 1'b0;
    wait_done(cyc, b1);
    start = 1'b0;
    check("ignore.latency", cyc, 5);
    check("ignore.flags", flags(), 3'b100);
    @(negedge clk);
    check("ignore.idle", busy, 1'b0);

    // start held in DONE: next compare begins without an IDLE cycle.
    launch(16'hA000, 16'h1000, 1'b0);
    wait_done(cyc, b1);
    check("b2b.first_latency", cyc, 2);
    check("b2b.first_flags", flags(), 3'b010);
    start     = 1'b1;
    a         = 16'h0001;
    b         = 16'h0002;
    is_signed = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, b1);
    check("b2b.no_idle", b1, 1'b1);
    check("b2b.second_latency", cyc, 5);
    check("b2b.second_flags", flags(), 3'b100);

    // Asynchronous reset in cycle 2 of a compare aborts it without done.
    launch(16'h0F00, 16'h00FF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.busy", busy, 1'b0);
    check("abort.done", done, 1'b0);
    check("abort.flags", flags(), 3'b000);
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      if (i == 2) rst_n = 1'b1;
    end
    check("abort.no_done", seen_done, 1'b0);
    check("abort.still_idle", busy, 1'b0);
    run_case("post_rst", 16'h00FF, 16'h0F00, 1'b0, 3'b100, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, the operand width in bits.
REQ-002 The module SHALL have parameter DIGIT, default 4, the bits compared per cycle; WIDTH SHALL be an integer multiple of DIGIT, and N = WIDTH/DIGIT.
REQ-003 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  request a comparison of a and b.
REQ-006 Port: a  input  WIDTH  operand A.
REQ-007 Port: b  input  WIDTH  operand B.
REQ-008 Port: is_signed  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-009 Port: busy  output  1  high while a comparison is in progress.
REQ-010 Port: done  output  1  one-cycle pulse when the result flags update.
REQ-011 Ports: a_lt_b, a_gt_b, a_eq_b  output  1 each  registered result flags.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, COMPARE and DONE.
REQ-013 The block SHALL accept start only when busy is 0 (state IDLE or DONE); start in COMPARE SHALL be ignored.
REQ-014 On an accepted start, the block SHALL capture a, b and is_signed, set digit index k = 0 (the MSB digit), and enter COMPARE.
REQ-015 When the signed mode is captured, the block SHALL invert bit WIDTH-1 of both captured operands so that the unsigned digit compare yields the signed order.
REQ-016 In each COMPARE cycle, the block SHALL compare digit k of A and B (bits WIDTH-1-k*DIGIT down to WIDTH-(k+1)*DIGIT).
REQ-017 If digit k differs, the block SHALL record gt or lt, enter DONE, and skip the remaining digits (early termination).
REQ-018 If digit k is equal and k < N-1, the block SHALL increment k and stay in COMPARE.
REQ-019 If k = N-1 and the digit is equal, the block SHALL record eq and enter DONE.
REQ-020 Latency: with start accepted at edge 0 and the first differing digit at index k, done SHALL be high in cycle k+2; when all digits are equal, done SHALL be high in cycle N+1.
REQ-021 In DONE, the block SHALL drive done = 1 for exactly one cycle, update all three flags in that same cycle, and go to IDLE, or back to COMPARE if start is present.
REQ-022 The result flags SHALL hold their value until the next done, and exactly one flag SHALL be high after any done.
REQ-023 Input changes on a, b and is_signed after capture SHALL NOT affect the comparison in progress.
REQ-024 busy SHALL be 1 in COMPARE only; done SHALL be 1 in DONE only.

Reset
REQ-025 When rst_n is low, the block SHALL immediately force state IDLE, k = 0, busy = 0, done = 0, and all three flags = 0, independent of clk.
REQ-026 A reset during COMPARE SHALL abort the operation with no done pulse; the first accepted start after rst_n rises SHALL proceed normally.

Structure
REQ-027 The FSM state encoding and the default WIDTH/DIGIT constants SHALL reside in a shared package, seq_cmp_pkg.
REQ-028 The per-digit comparison SHALL be a combinational sub-module, digit_compare (DIGIT-bit inputs; gt/lt/eq outputs), instantiated once.

Verification (WIDTH=16, DIGIT=4)
REQ-029 Unsigned a=0x1234, b=0x1235, start at edge 0 -> done in cycle 5, a_lt_b=1, others 0.
REQ-030 Unsigned a=0xA000, b=0x1000 -> done in cycle 2 (early exit), a_gt_b=1; the same operands with is_signed=1 -> a_lt_b=1.
REQ-031 a=b=0xBEEF, both modes -> done in cycle 5, a_eq_b=1.
REQ-032 Start pulsed again at cycle 1 with different operands -> ignored, and the result reflects the first operands; start held high during DONE -> back-to-back compare with no IDLE cycle.
REQ-033 rst_n driven low in cycle 2 of a compare -> busy=0 and flags=0 immediately, with no done pulse; the next compare is correct.
REQ-034 Signed 0x8000 vs 0x7FFF -> a_lt_b=1; signed 0xFFFF vs 0x0000 -> a_lt_b=1; unsigned 0xFFFF vs 0x0000 -> a_gt_b=1.
